delay_line: RTL and testbench
=============================

Name: delay_line

Overview:
- Parametrised, stallable multi-stage register delay line carrying a data word plus a valid bit.
- Generalises the fixed two-flop buffer chain: configurable width, maximum depth, run-time tap select, clock enable, flush and an occupancy counter.
- Used wherever pipeline paths must be delay-matched or re-timed, with the delay tunable without re-synthesis.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 4, number of register stages, i.e. maximum delay in cycles (>=2).
- SEL_W, $clog2(DEPTH+1), width of the tap-select and occupancy fields (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- en  in  1  shift enable; 0 holds all stages.
- flush  in  1  synchronous clear of all valid bits.
- in_valid  in  1  input sample valid.
- in_data  in  WIDTH  input sample.
- sel  in  SEL_W  tap select: delay in enabled cycles, 0..DEPTH.
- out_valid  out  1  valid of selected tap.
- out_data  out  WIDTH  data of selected tap.
- occ  out  SEL_W  count of valid samples held in stages 1..DEPTH.

Behaviour:
- Storage: stage k (1..DEPTH) holds {v[k], d[k]}. Stage 1 is nearest the input.
- Reset (rst=0, asynchronous): all v[k]=0, occ=0. With sel>=1: out_valid=0. Data reset is governed by the optional feature.
- Rising clk, en=1, flush=0:
  - {v[1],d[1]} <= {in_valid,in_data}.
  - {v[k],d[k]} <= {v[k-1],d[k-1]}.
  - The sample in stage DEPTH is discarded.
- Rising clk, en=0, flush=0: all stages hold. in_valid is ignored and the sample is lost; upstream must hold or stall.
- flush=1 (priority over en):
  - All v[k] <= 0, including the sample arriving that cycle. occ <= 0.
  - d[k] shifts if en=1, otherwise holds.
- Output mux (combinational):
  - sel=k, 1<=k<=DEPTH: out = {v[k], d[k]}. Latency = k enabled cycles.
  - sel=0: bypass, out = {in_valid, in_data}, zero latency.
  - sel>DEPTH: clamp to DEPTH.
- sel change mid-stream: the output follows the new tap in the same cycle.
  - Decreasing sel skips samples; increasing sel repeats samples.
  - No internal protection; the user changes sel only while flushed or idle.
- occ: registered. Next value = number of set v[k] after the update, computed incrementally:
  - +in_valid when en=1.
  - -v[DEPTH] when en=1.
  - 0 on flush.
  - Range 0..DEPTH, never wraps.
- No combinational path from in_* to outputs except sel=0 bypass.

Optional Feature:
- Macro DELAY_LINE_DATA_RST_EN.
- Defined: d[k] also reset to 0 asynchronously; out_data=0 after reset for any sel>=1.
- Undefined: d[k] have no reset (area/timing saving). out_data is undefined until overwritten; only valid bits and occ are reset.

Decomposition:
- Shared package delay_line_pkg: function clamp_sel (sel -> 1..DEPTH or bypass flag) and the SEL_W derivation function.
- One natural sub-module: delay_stage (single enabled register holding {valid,data}, with flush clear on valid and optional data reset), instantiated DEPTH times via generate.
- Mux and occ counter stay in the top.

Test Plan:
- Reset/latency: DEPTH=4, WIDTH=8, sel=2, en=1; drive valid 0xA5 at cycle 0 then in_valid=0 -> out_valid=1, out_data=0xA5 exactly at cycle 2; occ=1 for cycles 1..4, 0 from cycle 5.
- Stall: sel=3, drive 0x11,0x22,0x33 back-to-back; hold en=0 for 2 cycles after 0x22 enters -> output sequence 0x11,0x22,0x33 unchanged in order; each delayed by 3 enabled cycles; occ frozen during stall.
- Flush collision: line full (occ=4); assert flush with en=1 and in_valid=1, in_data=0x7E -> next cycle occ=0; all out_valid=0 for 4 cycles; 0x7E never appears.
- Bypass and clamp: sel=0, in_valid=1, in_data=0x3C -> same-cycle out=0x3C. sel=7 (DEPTH=4) -> behaves identically to sel=4.
- Continuous stream: DEPTH=8, WIDTH=16, incrementing counter each cycle, sel=8 -> out_data = input minus 8 every cycle after fill; occ saturates at 8.
- Async reset mid-operation: rst low between clock edges with occ=3 -> out_valid=0 and occ=0 immediately. out_data=0 only when DELAY_LINE_DATA_RST_EN is defined; run both builds.

Source files
------------

// File: rtl/delay_line_pkg.sv
// delay_line_pkg: shared helpers for the delay line.
//   sel_width(depth)      : width of the tap-select / occupancy fields, $clog2(depth+1).
//   clamp_sel(sel, depth) : maps a raw tap select to a stage index 1..depth,
//                           or 0 as the bypass flag (input passed straight through).
package delay_line_pkg;

    function automatic int sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Selects above the physical depth saturate at the last stage.
    function automatic logic [31:0] clamp_sel(input logic [31:0] sel, input int depth);
        return (sel > 32'(depth)) ? 32'(depth) : sel;
    endfunction

endpackage

// File: rtl/delay_stage.sv
// delay_stage: one enabled register stage holding {valid, data}.
// Build option: DELAY_LINE_DATA_RST_EN gives the data word an asynchronous reset;
// without it the data register is reset-free and only the valid bit is cleared.
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active-low
//   en         load enable; 0 holds the stage
//   flush      synchronous clear of the valid bit (wins over en)
//   prev_valid valid from the previous stage (or the line input)
//   prev_data  data from the previous stage (or the line input)
//   valid      stored valid bit
//   data       stored data word
module delay_stage
    import delay_line_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            valid <= 1'b0;
        else if (flush)
            valid <= 1'b0;
        else if (en)
            valid <= prev_valid;

    // Data keeps shifting under flush; only validity is discarded.
`ifdef DELAY_LINE_DATA_RST_EN
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            data <= '0;
        else if (en)
            data <= prev_data;
`else
    always_ff @(posedge clk)
        if (en)
            data <= prev_data;
`endif

endmodule

// File: rtl/delay_line.sv
// delay_line: stallable multi-stage register delay line with run-time tap select.
// Build option: DELAY_LINE_DATA_RST_EN also resets the stage data words to 0.
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active-low
//   en         shift enable; 0 holds every stage (input sample is dropped)
//   flush      synchronous clear of all valid bits and occupancy
//   in_valid   input sample valid
//   in_data    input sample
//   sel        tap select: 0 = bypass, 1..DEPTH = delay in enabled cycles, >DEPTH clamps
//   out_valid  valid of the selected tap
//   out_data   data of the selected tap
//   occ        number of valid samples held in stages 1..DEPTH
module delay_line
    import delay_line_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int SEL_W = sel_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0] sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [SEL_W-1:0] occ
);

    // Index 0 is the line input itself, so the bypass tap shares the stage mux.
    logic [DEPTH:0]   v;
    logic [WIDTH-1:0] d [0:DEPTH];
    logic [SEL_W-1:0] idx;

    assign v[0] = in_valid;
    assign d[0] = in_data;

    genvar k;
    generate
        for (k = 1; k <= DEPTH; k++) begin : g_stage
            delay_stage #(.WIDTH(WIDTH)) u_stage (
                .clk        (clk),
                .rst        (rst),
                .en         (en),
                .flush      (flush),
                .prev_valid (v[k-1]),
                .prev_data  (d[k-1]),
                .valid      (v[k]),
                .data       (d[k])
            );
        end
    endgenerate

    assign idx       = SEL_W'(clamp_sel(32'(sel), DEPTH));
    assign out_valid = v[idx];
    assign out_data  = d[idx];

    // occ <= DEPTH implies the last stage is valid whenever the line is full,
    // so the incremental update never leaves 0..DEPTH.
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            occ <= '0;
        else if (flush)
            occ <= '0;
        else if (en)
            occ <= occ + SEL_W'(in_valid) - SEL_W'(v[DEPTH]);

endmodule

// File: tb/tb_delay_line.sv
// tb_delay_line: self-checking bench for delay_line (DEPTH=4/WIDTH=8 and DEPTH=8/WIDTH=16).
module tb_delay_line;

    typedef struct packed {
        logic       v;
        logic       k;
        logic [7:0] d;
    } ent_t;

`ifdef DELAY_LINE_DATA_RST_EN
    localparam bit DRST = 1'b1;
`else
    localparam bit DRST = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic       a_en, a_flush, a_iv, a_ov;
    logic [7:0] a_id, a_od;
    logic [2:0] a_sel, a_occ;

    logic        b_en, b_flush, b_iv, b_ov;
    logic [15:0] b_id, b_od;
    logic [3:0]  b_sel, b_occ;

    delay_line #(.WIDTH(8), .DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .en(a_en), .flush(a_flush), .in_valid(a_iv), .in_data(a_id),
        .sel(a_sel), .out_valid(a_ov), .out_data(a_od), .occ(a_occ)
    );

    delay_line #(.WIDTH(16), .DEPTH(8)) dut_b (
        .clk(clk), .rst(rst), .en(b_en), .flush(b_flush), .in_valid(b_iv), .in_data(b_id),
        .sel(b_sel), .out_valid(b_ov), .out_data(b_od), .occ(b_occ)
    );

    int          tests = 0;
    int          fails = 0;
    ent_t        q[$];
    int          b_n;
    logic [15:0] b_base;
    bit          b_on = 1'b0;
    bit          cap = 1'b0;
    logic [7:0]  seen[$];
    logic [2:0]  occ_hold;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // q[i] is the sample that entered i+1 enabled cycles ago.
    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 4; i++) q.push_back({1'b0, DRST, 8'h00});
        b_n = 0;
    endtask

    task automatic check_a();
        int s;
        int n = 0;
        ent_t e;
        s = (a_sel > 3'd4) ? 4 : int'(a_sel);
        e = (s == 0) ? {a_iv, 1'b1, a_id} : q[s-1];
        foreach (q[i]) n += int'(q[i].v);
        chk("a_valid", 32'(a_ov), 32'(e.v));
        if (e.k) chk("a_data", 32'(a_od), 32'(e.d));
        chk("a_occ", 32'(a_occ), 32'(n));
    endtask

    // Stream into B: b_n samples of an incrementing counter since reset, tap 8.
    task automatic check_b();
        chk("b_occ", 32'(b_occ), 32'((b_n > 8) ? 8 : b_n));
        chk("b_valid", 32'(b_ov), 32'(b_n >= 8));
        if (b_n >= 8) chk("b_data", 32'(b_od), 32'(b_id - 16'd8));
    endtask

    task automatic cycle();
        #1;
        check_a();
        if (b_on) check_b();
        if (cap && a_en && a_ov) seen.push_back(a_od);
        @(posedge clk);
        if (a_en) begin
            q.push_front({a_iv & ~a_flush, 1'b1, a_id});
            void'(q.pop_back());
        end
        if (a_flush) foreach (q[i]) q[i].v = 1'b0;
        if (b_en) b_n++;
        #1;
    endtask

    initial begin
        rst = 1'b0;
        {a_en, a_flush, a_iv, a_id} = '0;
        a_sel = 3'd2;
        {b_en, b_flush, b_iv, b_id} = '0;
        b_sel = 4'd8;
        model_reset();
        #2;
        chk("reset_a_valid", 32'(a_ov), 0);
        chk("reset_a_occ", 32'(a_occ), 0);
        chk("reset_b_valid", 32'(b_ov), 0);
        chk("reset_b_occ", 32'(b_occ), 0);
        #10 rst = 1'b1;
        @(posedge clk);
        #1;

        // Latency: one sample at tap 2
        a_en = 1'b1; a_iv = 1'b1; a_id = 8'hA5;
        cycle();
        a_iv = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            chk("lat_valid", 32'(a_ov), 32'(i == 2));
            if (i == 2) chk("lat_data", 32'(a_od), 32'hA5);
            chk("lat_occ", 32'(a_occ), (i <= 4) ? 1 : 0);
            cycle();
        end

        // Stall in the middle of a burst at tap 3
        a_sel = 3'd3; cap = 1'b1;
        a_iv = 1'b1; a_id = 8'h11; cycle();
        a_id = 8'h22; cycle();
        a_en = 1'b0; a_id = 8'h99;
        repeat (2) begin
            cycle();
            chk("stall_occ", 32'(a_occ), 2);
        end
        a_en = 1'b1; a_id = 8'h33; cycle();
        a_iv = 1'b0;
        repeat (5) cycle();
        cap = 1'b0;
        chk("stall_count", 32'(seen.size()), 3);
        if (seen.size() == 3) begin
            chk("stall_seq0", 32'(seen[0]), 32'h11);
            chk("stall_seq1", 32'(seen[1]), 32'h22);
            chk("stall_seq2", 32'(seen[2]), 32'h33);
        end

        // Flush colliding with an incoming sample on a full line
        a_sel = 3'd4; a_iv = 1'b1;
        repeat (4) begin
            a_id = 8'($urandom);
            cycle();
        end
        chk("full_occ", 32'(a_occ), 4);
        a_flush = 1'b1; a_id = 8'h7E;
        cycle();
        a_flush = 1'b0; a_iv = 1'b0;
        chk("flush_occ", 32'(a_occ), 0);
        repeat (4) begin
            for (int s = 1; s <= 4; s++) begin
                a_sel = 3'(s);
                #1 chk("flush_valid", 32'(a_ov), 0);
            end
            a_sel = 3'd4;
            cycle();
        end

        // Bypass and clamp
        a_sel = 3'd0; a_iv = 1'b1; a_id = 8'h3C;
        #1;
        chk("bypass_valid", 32'(a_ov), 1);
        chk("bypass_data", 32'(a_od), 32'h3C);
        cycle();
        a_sel = 3'd4;
        repeat (4) begin
            a_id = 8'($urandom);
            cycle();
        end
        a_en = 1'b0; a_iv = 1'b0; a_sel = 3'd7;
        #1;
        chk("clamp_valid", 32'(a_ov), 32'(q[3].v));
        chk("clamp_data", 32'(a_od), 32'(q[3].d));
        cycle();

        // Continuous counter stream through the DEPTH=8 line
        b_base = 16'($urandom);
        b_en = 1'b1; b_iv = 1'b1; b_on = 1'b1;
        repeat (20) begin
            b_id = b_base + 16'(b_n);
            cycle();
        end
        b_on = 1'b0; b_en = 1'b0; b_iv = 1'b0;
        chk("b_saturate", 32'(b_occ), 8);

        // Randomised traffic, sel changes included
        repeat (300) begin
            a_en    = ($urandom_range(0, 3) != 0);
            a_flush = ($urandom_range(0, 19) == 0);
            a_iv    = 1'($urandom_range(0, 1));
            a_id    = 8'($urandom);
            a_sel   = 3'($urandom_range(0, 7));
            cycle();
        end

        // Asynchronous reset between edges with three samples held
        a_flush = 1'b1; a_en = 1'b0; a_iv = 1'b0;
        cycle();
        a_flush = 1'b0; a_en = 1'b1; a_iv = 1'b1;
        repeat (3) begin
            a_id = 8'($urandom);
            cycle();
        end
        a_en = 1'b0; a_iv = 1'b0; a_sel = 3'd2;
        cycle();
        chk("pre_rst_occ", 32'(a_occ), 3);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", 32'(a_ov), 0);
        chk("arst_occ", 32'(a_occ), 0);
        chk("arst_b_occ", 32'(b_occ), 0);
        chk("arst_b_valid", 32'(b_ov), 0);
`ifdef DELAY_LINE_DATA_RST_EN
        chk("arst_b_data", 32'(b_od), 0);
        for (int s = 1; s <= 4; s++) begin
            a_sel = 3'(s);
            #1 chk("arst_data", 32'(a_od), 0);
        end
`endif
        model_reset();
        rst = 1'b1;
        repeat (60) begin
            a_en    = ($urandom_range(0, 3) != 0);
            a_flush = ($urandom_range(0, 19) == 0);
            a_iv    = 1'($urandom_range(0, 1));
            a_id    = 8'($urandom);
            a_sel   = 3'($urandom_range(0, 7));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
